// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with branch resolve, forwarding tap and retire count
module ex_mem_stage #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int COUNT_WIDTH    = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      stall,
   input  logic                      flush,
   input  logic                      in_valid,
   input  logic [DATA_WIDTH-1:0]     ALU_result,
   input  logic                      zero,
   input  logic [DATA_WIDTH-1:0]     rt_data,
   input  logic [DATA_WIDTH-1:0]     branch_target,
   input  logic [REG_ADDR_WIDTH-1:0] write_reg,
   input  logic                      RegWrite,
   input  logic                      MemRead,
   input  logic                      MemWrite,
   input  logic                      MemtoReg,
   input  logic                      Branch,
   input  logic                      BranchNE,
   output logic                      mem_valid,
   output logic [DATA_WIDTH-1:0]     mem_ALU_result,
   output logic [DATA_WIDTH-1:0]     mem_store_data,
   output logic [REG_ADDR_WIDTH-1:0] mem_write_reg,
   output logic                      mem_RegWrite,
   output logic                      mem_MemRead,
   output logic                      mem_MemWrite,
   output logic                      mem_MemtoReg,
   output logic                      mem_branch_taken,
   output logic [DATA_WIDTH-1:0]     mem_branch_target,
   output logic                      fwd_en,
   output logic                      ctrl_err,
   output logic [COUNT_WIDTH-1:0]    issued_count
);

   logic illegal;
   logic legal;

   // A simultaneous read+write request is turned into a bubble rather than passed on.
   assign illegal = in_valid & MemRead & MemWrite;
   assign legal   = in_valid & ~illegal;
   assign fwd_en  = mem_valid & mem_RegWrite;

   always_ff @(posedge clock) begin
      if (reset) begin
         mem_valid         <= 1'b0;
         mem_ALU_result    <= '0;
         mem_store_data    <= '0;
         mem_write_reg     <= '0;
         mem_RegWrite      <= 1'b0;
         mem_MemRead       <= 1'b0;
         mem_MemWrite      <= 1'b0;
         mem_MemtoReg      <= 1'b0;
         mem_branch_taken  <= 1'b0;
         mem_branch_target <= '0;
         ctrl_err          <= 1'b0;
         issued_count      <= '0;
      end else if (flush) begin
         // Data fields keep their old contents; only the qualifiers are killed.
         mem_valid        <= 1'b0;
         mem_RegWrite     <= 1'b0;
         mem_MemRead      <= 1'b0;
         mem_MemWrite     <= 1'b0;
         mem_MemtoReg     <= 1'b0;
         mem_branch_taken <= 1'b0;
      end else if (!stall) begin
         mem_ALU_result    <= ALU_result;
         mem_store_data    <= rt_data;
         mem_write_reg     <= write_reg;
         mem_branch_target <= branch_target;
         mem_valid         <= legal;
         mem_RegWrite      <= legal & RegWrite & (write_reg != '0);
         mem_MemRead       <= legal & MemRead;
         mem_MemWrite      <= legal & MemWrite;
         mem_MemtoReg      <= legal & MemtoReg;
         mem_branch_taken  <= legal & Branch & (BranchNE ? ~zero : zero);
         if (illegal)
            ctrl_err <= 1'b1;
         if (legal)
            issued_count <= issued_count + 1'b1;
      end
   end

endmodule
